button_debouncer: RTL
=====================

# button_debouncer

Conditions one raw, asynchronous, mechanically bouncing input (push-button or slide switch) into a clean, clock-domain-safe level plus single-cycle edge pulses. It sits between the board input pin and the registered logic downstream: toggle flops, counters, and FSM enables. Those consumers sample `o_level` or use `o_rise` / `o_fall` as one-cycle enables. The block combines a synchronizer chain, a stability counter and a 4-state FSM.

## Interface
- `SYNC_STAGES`, default 2: number of synchronizer flops on `i_bouncy`. Legal range 2–4.
- `STABLE_CYCLES`, default 250000: consecutive synchronized samples required to accept a new level. This is 10 ms at 25 MHz. Legal minimum is 2; an elaboration-time check rejects smaller values.
- `i_clk`, input, 1: system clock; all state updates on its rising edge.
- `i_reset`, input, 1: reset, asynchronous, active-high.
- `i_bouncy`, input, 1: raw pin, asynchronous to `i_clk`, may bounce.
- `o_level`, output, 1: debounced level, registered.
- `o_rise`, output, 1: one-cycle pulse when `o_level` goes 0→1, registered.
- `o_fall`, output, 1: one-cycle pulse when `o_level` goes 1→0, registered. Active only with `DEBOUNCE_FALL_PULSE_EN`.

## Operation
- **Synchronizer:** `i_bouncy` passes through `SYNC_STAGES` flops. The last stage is the synchronized input `s`. No logic is placed between stages.
- **Counter:** width is `$clog2(STABLE_CYCLES)`. It never exceeds `STABLE_CYCLES-1`, so there is no wrap.
- **FSM states:** IDLE_LOW, CHECK_HIGH, IDLE_HIGH, CHECK_LOW.
- **IDLE_LOW:**
  - `s`=1 → CHECK_HIGH, cnt←1.
  - Otherwise hold, cnt←0.
- **CHECK_HIGH:**
  - `s`=0 → IDLE_LOW, cnt←0. A bounce restarts qualification.
  - `s`=1 and cnt==`STABLE_CYCLES-1` → IDLE_HIGH, cnt←0, `o_level`←1, `o_rise`←1.
  - `s`=1 otherwise → cnt←cnt+1.
- **IDLE_HIGH / CHECK_LOW:** mirror image of the above with `s` inverted. The accept transition sets `o_level`←0 and `o_fall`←1 (macro permitting).
- **Pulses:** `o_rise` and `o_fall` are high for exactly one cycle and are cleared on the following edge unconditionally. They are never high simultaneously.
- **`o_level` invariant:** `o_level`=1 exactly in IDLE_HIGH and CHECK_LOW.
- **Reset:** clears synchronizer flops to 0, state to IDLE_LOW, cnt to 0, and `o_level`/`o_rise`/`o_fall` to 0.
  - Reset mid-CHECK abandons qualification.
  - If `i_bouncy` is still high after reset release, the block requalifies from scratch and emits a fresh `o_rise`.

## Timing
- **Acceptance latency:** `i_bouncy` stable high, first sampled at edge 1 → `o_level` and `o_rise` rise at edge `SYNC_STAGES+STABLE_CYCLES`. Release latency is identical for `o_level`/`o_fall`.
- **Minimum accepted pulse:** `s` must be stable for `STABLE_CYCLES` consecutive sampling edges. Any shorter excursion produces no output change.
- **Reset assertion:** outputs go to 0 asynchronously; no clock is required.
- **Reset release:** first state update happens on the first rising edge after deassertion.
- **Throughput:** at most one accepted transition per `STABLE_CYCLES` cycles.

## Configuration
- Macro: `DEBOUNCE_FALL_PULSE_EN`.
- **Defined:** `o_fall` pulses for one cycle on each accepted 1→0 transition, as specified above.
- **Undefined:** `o_fall` is tied to constant 0 and its register is not built. The port list is unchanged, so instantiations do not change. `o_level` and `o_rise` behaviour is identical in both builds.

## Test plan
All scenarios use `SYNC_STAGES`=2, `STABLE_CYCLES`=4; edges are numbered from the first rising edge after reset deassertion.

- **Clean press:** `i_bouncy`=1 from before edge 1 → `o_level`=1 and `o_rise`=1 at edge 6; `o_rise`=0 at edge 7; `o_level` stays 1.
- **Glitch rejection:** `i_bouncy` high for 3 cycles then low → `o_level`, `o_rise` stay 0 throughout; FSM returns to IDLE_LOW.
- **Bounce train:** pattern 1,0,1,1,0,1,1,1,1… → no output until 4 consecutive synchronized 1s; exactly one `o_rise` pulse results.
- **Release with macro defined:** after the clean press, drive `i_bouncy`=0 → `o_level`=0 and `o_fall`=1 for one cycle 6 edges after the first low sample. Without the macro, `o_fall` stays 0 throughout.
- **Reset mid-qualification:** assert `i_reset` with FSM in CHECK_HIGH and cnt=2 → all outputs 0 immediately (asynchronous), with input held high. After release, `o_rise` occurs at edge 6.
- **Reset in IDLE_HIGH:** assert `i_reset` while in IDLE_HIGH with input held high → `o_level` drops asynchronously. After release, it re-asserts with a new `o_rise` at edge 6.

Source files
------------

// File: rtl/button_debouncer.sv
// button_debouncer: turns a raw, bouncing, asynchronous pin into a clean
// registered level plus one-cycle rise/fall enables.
// Input path: SYNC_STAGES-flop synchronizer -> stability counter -> 4-state FSM.
// Build option: define DEBOUNCE_FALL_PULSE_EN to build the o_fall pulse
// register. Otherwise o_fall is tied low and the port list stays unchanged.
//
// state      | meaning
// IDLE_LOW   | level accepted low, waiting for s=1
// CHECK_HIGH | s=1 seen, counting consecutive high samples
// IDLE_HIGH  | level accepted high, waiting for s=0
// CHECK_LOW  | s=0 seen, counting consecutive low samples

module button_debouncer #(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 250000
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_bouncy,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    localparam int CW = $clog2(STABLE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    generate
        if (STABLE_CYCLES < 2) begin : g_bad_stable
            $error("button_debouncer: STABLE_CYCLES must be at least 2");
        end
        if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
            $error("button_debouncer: SYNC_STAGES must be in 2..4");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE_LOW   = 2'd0,
        CHECK_HIGH = 2'd1,
        IDLE_HIGH  = 2'd2,
        CHECK_LOW  = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    state_t                 state_q;
    logic [CW-1:0]          cnt_q;
    logic                   level_q;
    logic                   rise_q;

    assign s = sync_q[SYNC_STAGES-1];

    // Plain flop chain; nothing between stages so metastability can settle.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], i_bouncy};
        end
    end

`ifdef DEBOUNCE_FALL_PULSE_EN
    logic fall_q;
`endif

    // Qualification FSM: a level is accepted after STABLE_CYCLES agreeing samples.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= IDLE_LOW;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
`ifdef DEBOUNCE_FALL_PULSE_EN
            fall_q  <= 1'b0;
`endif
        end else begin
            rise_q <= 1'b0;
`ifdef DEBOUNCE_FALL_PULSE_EN
            fall_q <= 1'b0;
`endif
            case (state_q)
                IDLE_LOW: begin
                    if (s) begin
                        state_q <= CHECK_HIGH;
                        cnt_q   <= CNT_ONE;
                    end else begin
                        cnt_q   <= '0;
                    end
                end
                CHECK_HIGH: begin
                    if (!s) begin
                        state_q <= IDLE_LOW;
                        cnt_q   <= '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q <= IDLE_HIGH;
                        cnt_q   <= '0;
                        level_q <= 1'b1;
                        rise_q  <= 1'b1;
                    end else begin
                        cnt_q   <= cnt_q + CNT_ONE;
                    end
                end
                IDLE_HIGH: begin
                    if (!s) begin
                        state_q <= CHECK_LOW;
                        cnt_q   <= CNT_ONE;
                    end else begin
                        cnt_q   <= '0;
                    end
                end
                CHECK_LOW: begin
                    if (s) begin
                        state_q <= IDLE_HIGH;
                        cnt_q   <= '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q <= IDLE_LOW;
                        cnt_q   <= '0;
                        level_q <= 1'b0;
`ifdef DEBOUNCE_FALL_PULSE_EN
                        fall_q  <= 1'b1;
`endif
                    end else begin
                        cnt_q   <= cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_q <= IDLE_LOW;
                    cnt_q   <= '0;
                    level_q <= 1'b0;
                end
            endcase
        end
    end

    assign o_level = level_q;
    assign o_rise  = rise_q;
`ifdef DEBOUNCE_FALL_PULSE_EN
    assign o_fall  = fall_q;
`else
    assign o_fall  = 1'b0;
`endif

endmodule
